// File: rtl/src_ptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: accepts writes, keeps
// binary/Gray write pointers and derives full, almost-full and level from the synced read pointer.
module src_ptr_ctrl #(
    parameter int unsigned ASIZE        = 4,
    parameter int unsigned AFULL_THRESH = 2
) (
    input  logic             src_clk,
    input  logic             src_rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic             ram_wen,
    output logic [ASIZE-1:0] ram_waddr,
    output logic [ASIZE:0]   src_ptr,
    input  logic [ASIZE:0]   rptr_sync,
    output logic             full,
    output logic             afull,
    output logic [ASIZE:0]   level
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] AFULL_LEVEL = (ASIZE + 1)'(DEPTH - AFULL_THRESH);

    logic [ASIZE:0] wbin_q, wbin_d;
    logic [ASIZE:0] wgray_q, wgray_d;
    logic [ASIZE:0] level_q, level_d;
    logic           full_q, full_d;
    logic           afull_q, afull_d;
    logic [ASIZE:0] rbin;
    logic           accept;

    // Ready depends only on registered full and reset, never on this cycle's request.
    assign wr_ready  = ~full_q & ~src_rst;
    assign accept    = wr_valid & wr_ready;
    assign ram_wen   = accept;
    assign ram_waddr = wbin_q[ASIZE-1:0];
    assign src_ptr   = wgray_q;
    assign full      = full_q;
    assign afull     = afull_q;
    assign level     = level_q;

    always_comb begin
        rbin        = '0;
        rbin[ASIZE] = rptr_sync[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rptr_sync[i];
        end
    end

    always_comb begin
        wbin_d  = wbin_q + {{ASIZE{1'b0}}, accept};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        level_d = wbin_d - rbin;
        // Full when write Gray equals read Gray with its top two bits inverted.
        full_d  = (wgray_d == {~rptr_sync[ASIZE:ASIZE-1], rptr_sync[ASIZE-2:0]});
        afull_d = (level_d >= AFULL_LEVEL);
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

endmodule
